toy_regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register pending-write scoreboard, optional same-cycle write-to-read bypass and write-collision reporting. It sits between decode/issue (read, allocate) and the execution writeback channels. It replaces the fixed 4-write/8-read file and generalises width, depth and port count.

---
 rtl/toy_regfile_mp.sv | 132 +++++++++++++
 tb/tb_toy_regfile_mp.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_regfile_mp.sv
// -----------------------------------------------------------------------------
// toy_regfile_mp
//   Multi-port integer register file with a per-register pending-write
//   scoreboard, optional same-cycle write-to-read bypass and write-collision
//   reporting. Register 0 is hard-wired to zero and is never busy.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   wr_en/idx/data  WR_CH_NUM writeback channels; the lowest enabled channel
//                   wins when several target one index
//   rd_idx          RD_CH_NUM read source indices
//   rd_data/busy    combinational read data and "producer outstanding" flag
//   alloc_en/idx    issue marks a destination register as pending
//   flush           clears every busy bit at the next edge (data untouched)
//   wr_conflict     registered pulse: >=2 enabled channels hit one nonzero
//                   index in the previous cycle
//   busy_cnt        registered population count of the busy bits
// -----------------------------------------------------------------------------
module toy_regfile_mp #(
  parameter  int REG_WIDTH = 32,
  parameter  int REG_NUM   = 32,
  parameter  int WR_CH_NUM = 4,
  parameter  int RD_CH_NUM = 8,
  parameter  int BYPASS    = 1,
  localparam int IDX_W     = $clog2(REG_NUM),
  localparam int CNT_W     = $clog2(REG_NUM) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [WR_CH_NUM-1:0]                 wr_en,
  input  logic [WR_CH_NUM-1:0][IDX_W-1:0]      wr_idx,
  input  logic [WR_CH_NUM-1:0][REG_WIDTH-1:0]  wr_data,
  input  logic [RD_CH_NUM-1:0][IDX_W-1:0]      rd_idx,
  output logic [RD_CH_NUM-1:0][REG_WIDTH-1:0]  rd_data,
  output logic [RD_CH_NUM-1:0]                 rd_busy,
  input  logic                                 alloc_en,
  input  logic [IDX_W-1:0]                     alloc_idx,
  input  logic                                 flush,
  output logic                                 wr_conflict,
  output logic [CNT_W-1:0]                     busy_cnt
);

  logic [REG_WIDTH-1:0] r_regs [REG_NUM];
  logic [REG_NUM-1:0]   r_busy;
  logic                 r_wr_conflict;
  logic [CNT_W-1:0]     r_busy_cnt;

  logic [REG_NUM-1:0]   w_hit;                 // some channel writes index i
  logic [REG_WIDTH-1:0] w_win_data [REG_NUM];  // winning channel's data
  logic                 w_conflict;
  logic [REG_NUM-1:0]   w_busy_nxt;
  logic [CNT_W-1:0]     w_busy_cnt_nxt;

  // Write arbitration: walk channels from highest to lowest so the
  // lowest-numbered enabled channel is the last assignment and wins.
  // NOTE: every combinational output gets a default before the loop; without
  // it an index no channel targets would hold its old value and infer a latch.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < REG_NUM; i++) w_win_data[i] = '0;
    for (int ch = WR_CH_NUM - 1; ch >= 0; ch--) begin
      if (wr_en[ch]) begin
        w_hit[wr_idx[ch]]      = 1'b1;
        w_win_data[wr_idx[ch]] = wr_data[ch];
      end
    end
    w_hit[0] = 1'b0;  // writes to register 0 are discarded
  end

  // Collision: any pair of enabled channels on the same nonzero index.
  always_comb begin
    w_conflict = 1'b0;
    for (int a = 0; a < WR_CH_NUM; a++) begin
      for (int b = a + 1; b < WR_CH_NUM; b++) begin
        if (wr_en[a] && wr_en[b] && (wr_idx[a] == wr_idx[b]) && (wr_idx[a] != '0))
          w_conflict = 1'b1;
      end
    end
  end

  // Scoreboard update. Priority low->high: writeback clear, alloc set, flush.
  // Alloc beats a same-cycle writeback because the new producer is younger.
  always_comb begin
    w_busy_nxt = r_busy & ~w_hit;
    if (alloc_en && (alloc_idx != '0)) w_busy_nxt[alloc_idx] = 1'b1;
    if (flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;

    w_busy_cnt_nxt = '0;
    for (int i = 0; i < REG_NUM; i++) w_busy_cnt_nxt = w_busy_cnt_nxt + CNT_W'(w_busy_nxt[i]);
  end

  // NOTE: the data array is reset as well, because a reset mid-operation must
  // discard architectural state; this costs a reset net on every flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
      r_busy        <= '0;
      r_wr_conflict <= 1'b0;
      r_busy_cnt    <= '0;
    end else begin
      r_regs[0] <= '0;
      for (int i = 1; i < REG_NUM; i++) begin
        if (w_hit[i]) r_regs[i] <= w_win_data[i];
      end
      r_busy        <= w_busy_nxt;
      r_wr_conflict <= w_conflict;
      r_busy_cnt    <= w_busy_cnt_nxt;
    end
  end

  // Reads. With bypass, a same-cycle write supplies the data and means the
  // producer has just completed, so the source is reported not busy.
  always_comb begin
    for (int r = 0; r < RD_CH_NUM; r++) begin
      rd_data[r] = '0;
      rd_busy[r] = 1'b0;
      if (rd_idx[r] != '0) begin
        if ((BYPASS != 0) && w_hit[rd_idx[r]]) begin
          rd_data[r] = w_win_data[rd_idx[r]];
        end else begin
          rd_data[r] = r_regs[rd_idx[r]];
          rd_busy[r] = r_busy[rd_idx[r]];
        end
      end
    end
  end

  assign wr_conflict = r_wr_conflict;
  assign busy_cnt    = r_busy_cnt;

endmodule

// File: tb/tb_toy_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_toy_regfile_mp
//   Drives a bypassing and a non-bypassing default-sized register file from
//   the same inputs and compares both against one array-based model of the
//   architectural state. A third instance (64 regs, 2 write, 3 read ports)
//   covers the zero register and non-default parameters with directed values.
// -----------------------------------------------------------------------------
module tb_toy_regfile_mp;

  typedef logic [31:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two default-parameter instances
  logic [3:0]        wr_en;
  logic [3:0][4:0]   wr_idx;
  logic [3:0][31:0]  wr_data;
  logic [7:0][4:0]   rd_idx;
  logic              alloc_en;
  logic [4:0]        alloc_idx;
  logic              flush;

  logic [7:0][31:0]  rd_data_b, rd_data_n;
  logic [7:0]        rd_busy_b, rd_busy_n;
  logic              conf_b, conf_n;
  logic [5:0]        cnt_b, cnt_n;

  // Stimulus / outputs for the 64-entry instance
  logic [1:0]        p_wr_en;
  logic [1:0][5:0]   p_wr_idx;
  logic [1:0][31:0]  p_wr_data;
  logic [2:0][5:0]   p_rd_idx;
  logic              p_alloc_en;
  logic [5:0]        p_alloc_idx;
  logic              p_flush;
  logic [2:0][31:0]  p_rd_data;
  logic [2:0]        p_rd_busy;
  logic              p_conf;
  logic [6:0]        p_cnt;

  toy_regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .flush(flush),
    .wr_conflict(conf_b), .busy_cnt(cnt_b));

  toy_regfile_mp #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .flush(flush),
    .wr_conflict(conf_n), .busy_cnt(cnt_n));

  toy_regfile_mp #(.REG_NUM(64), .WR_CH_NUM(2), .RD_CH_NUM(3), .BYPASS(1)) u_par (
    .clk(clk), .rst_n(rst_n), .wr_en(p_wr_en), .wr_idx(p_wr_idx), .wr_data(p_wr_data),
    .rd_idx(p_rd_idx), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
    .alloc_en(p_alloc_en), .alloc_idx(p_alloc_idx), .flush(p_flush),
    .wr_conflict(p_conf), .busy_cnt(p_cnt));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the default instances' architectural state
  word_t m_regs [32];
  bit    m_busy [32];
  bit    m_conf;
  int    m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
    m_cnt  = 0;
  endtask

  // Expected read for the current inputs and model state
  function automatic void exp_rd(input logic [4:0] idx, input bit byp,
                                 output word_t d, output bit b);
    bit found = 1'b0;
    d = m_regs[idx];
    b = m_busy[idx];
    if (idx == 5'd0) begin
      d = '0;
      b = 1'b0;
    end else if (byp) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!found && wr_en[ch] && wr_idx[ch] == idx) begin
          found = 1'b1;
          d = wr_data[ch];
          b = 1'b0;
        end
      end
    end
  endfunction

  // One clock edge: compute the model's next state from the inputs being
  // driven, take the edge, then settle 1 time unit past it.
  task automatic tick();
    word_t n_regs [32];
    bit    n_busy [32];
    bit    taken  [32];
    int    hits   [32];
    n_regs = m_regs;
    n_busy = m_busy;
    for (int i = 0; i < 32; i++) begin
      taken[i] = 1'b0;
      hits[i]  = 0;
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (wr_en[ch]) begin
        hits[wr_idx[ch]]++;
        if (wr_idx[ch] != 5'd0 && !taken[wr_idx[ch]]) begin
          taken[wr_idx[ch]]  = 1'b1;
          n_regs[wr_idx[ch]] = wr_data[ch];
          n_busy[wr_idx[ch]] = 1'b0;
        end
      end
    end
    if (alloc_en && alloc_idx != 5'd0) n_busy[alloc_idx] = 1'b1;
    if (flush) for (int i = 0; i < 32; i++) n_busy[i] = 1'b0;
    @(posedge clk);
    m_regs = n_regs;
    m_busy = n_busy;
    m_conf = 1'b0;
    m_cnt  = 0;
    for (int i = 1; i < 32; i++) begin
      if (hits[i] >= 2) m_conf = 1'b1;
      if (n_busy[i]) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_idx = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_idx = '0; flush = 1'b0;
    p_wr_en = '0; p_wr_idx = '0; p_wr_data = '0;
    p_alloc_en = 1'b0; p_alloc_idx = '0; p_flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rd_idx = '0;
    p_rd_idx = '0;
    model_reset();
    // Hammer writes, allocs and a collision while reset is held
    wr_en = 4'hF;
    wr_idx = {5'd3, 5'd3, 5'd9, 5'd12};
    wr_data = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    alloc_en = 1'b1; alloc_idx = 5'd7;
    p_wr_en = 2'b11; p_wr_idx = {6'd40, 6'd40}; p_wr_data = {32'h5, 32'h6};
    for (int r = 0; r < 8; r++) rd_idx[r] = 5'(r + 3);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rd_data_n !== '0 || rd_busy_n !== '0) begin
      n_errors++;
      $display("FAIL reset_rd_nobyp got data=%h busy=%b exp all zero", rd_data_n, rd_busy_n);
    end
    n_checks++;
    if (cnt_b !== 6'd0 || conf_b !== 1'b0 || cnt_n !== 6'd0 || conf_n !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_regs got cnt=%0d/%0d conf=%b/%b exp 0", cnt_b, cnt_n, conf_b, conf_n);
    end
    n_checks++;
    if (p_cnt !== 7'd0 || p_conf !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_par got cnt=%0d conf=%b exp 0", p_cnt, p_conf);
    end
    idle();
    #1;
    n_checks++;
    if (rd_data_b !== '0 || rd_busy_b !== '0) begin
      n_errors++;
      $display("FAIL reset_rd_byp got data=%h busy=%b exp all zero", rd_data_b, rd_busy_b);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic_write();
    word_t old5;
    idle();
    old5 = m_regs[5];
    wr_en[2] = 1'b1; wr_idx[2] = 5'd5; wr_data[2] = 32'hDEAD_BEEF;
    rd_idx[0] = 5'd5;
    #1;
    n_checks++;
    if (rd_data_b[0] !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL basic_bypass got %h exp %h", rd_data_b[0], 32'hDEAD_BEEF);
    end
    n_checks++;
    if (rd_data_n[0] !== old5) begin
      n_errors++;
      $display("FAIL basic_nobyp_old got %h exp %h", rd_data_n[0], old5);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_data_n[0] !== 32'hDEAD_BEEF || rd_data_b[0] !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL basic_after got %h/%h exp %h", rd_data_b[0], rd_data_n[0], 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_collision();
    idle();
    wr_en[1] = 1'b1; wr_idx[1] = 5'd7; wr_data[1] = 32'h11;
    wr_en[3] = 1'b1; wr_idx[3] = 5'd7; wr_data[3] = 32'h33;
    rd_idx[1] = 5'd7;
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_data_b[1] !== 32'h11 || rd_data_n[1] !== 32'h11) begin
      n_errors++;
      $display("FAIL coll_winner got %h/%h exp %h", rd_data_b[1], rd_data_n[1], 32'h11);
    end
    n_checks++;
    if (conf_b !== 1'b1 || conf_n !== 1'b1) begin
      n_errors++;
      $display("FAIL coll_pulse got %b/%b exp 1", conf_b, conf_n);
    end
    tick();
    n_checks++;
    if (conf_b !== 1'b0) begin
      n_errors++;
      $display("FAIL coll_clear got %b exp 0", conf_b);
    end
    wr_en[0] = 1'b1; wr_idx[0] = 5'd0; wr_data[0] = 32'hAA;
    wr_en[2] = 1'b1; wr_idx[2] = 5'd0; wr_data[2] = 32'hBB;
    rd_idx[2] = 5'd0;
    #1;
    n_checks++;
    if (rd_data_b[2] !== 32'h0 || rd_busy_b[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL coll_x0_read got %h/%b exp 0/0", rd_data_b[2], rd_busy_b[2]);
    end
    tick();
    idle();
    n_checks++;
    if (conf_b !== 1'b0 || conf_n !== 1'b0) begin
      n_errors++;
      $display("FAIL coll_x0 got %b/%b exp 0", conf_b, conf_n);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    alloc_en = 1'b1; alloc_idx = 5'd9;
    tick();
    idle();
    rd_idx[0] = 5'd9;
    #1;
    n_checks++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1 || cnt_b !== 6'd1) begin
      n_errors++;
      $display("FAIL sb_alloc got busy=%b/%b cnt=%0d exp 1/1 cnt=1", rd_busy_b[0], rd_busy_n[0], cnt_b);
    end
    wr_en[0] = 1'b1; wr_idx[0] = 5'd9; wr_data[0] = 32'h9999;
    #1;
    n_checks++;
    if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sb_wb_same got busy=%b/%b exp 0/1", rd_busy_b[0], rd_busy_n[0]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (cnt_b !== 6'd0 || cnt_n !== 6'd0 || rd_busy_n[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL sb_wb_next got cnt=%0d/%0d busy=%b exp 0/0/0", cnt_b, cnt_n, rd_busy_n[0]);
    end
  endtask

  task automatic test_alloc_race();
    idle();
    alloc_en = 1'b1; alloc_idx = 5'd4;
    wr_en[0] = 1'b1; wr_idx[0] = 5'd4; wr_data[0] = 32'h55;
    tick();
    idle();
    rd_idx[0] = 5'd4; rd_idx[1] = 5'd6;
    #1;
    n_checks++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1 || rd_data_b[0] !== 32'h55
        || rd_data_n[0] !== 32'h55 || cnt_b !== 6'd1) begin
      n_errors++;
      $display("FAIL race_alloc_wins got busy=%b/%b data=%h/%h cnt=%0d exp 1/1 55/55 cnt=1",
               rd_busy_b[0], rd_busy_n[0], rd_data_b[0], rd_data_n[0], cnt_b);
    end
    flush = 1'b1; alloc_en = 1'b1; alloc_idx = 5'd6;
    tick();
    idle();
    #1;
    n_checks++;
    if (cnt_b !== 6'd0 || rd_busy_b[0] !== 1'b0 || rd_busy_b[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL race_flush got cnt=%0d busy4=%b busy6=%b exp 0/0/0", cnt_b, rd_busy_b[0], rd_busy_b[1]);
    end
  endtask

  task automatic test_params();
    idle();
    p_wr_en = 2'b10; p_wr_idx[1] = 6'd63; p_wr_data[1] = 32'hA5A5_0001;
    p_alloc_en = 1'b1; p_alloc_idx = 6'd0;
    p_rd_idx = {6'd63, 6'd0, 6'd63};
    #1;
    n_checks++;
    if (p_rd_data[0] !== 32'hA5A5_0001) begin
      n_errors++;
      $display("FAIL par_bypass got %h exp %h", p_rd_data[0], 32'hA5A5_0001);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (p_rd_data[2] !== 32'hA5A5_0001 || p_rd_busy[1] !== 1'b0 || p_cnt !== 7'd0) begin
      n_errors++;
      $display("FAIL par_x63_x0 got data=%h busy0=%b cnt=%0d exp a5a50001/0/0", p_rd_data[2], p_rd_busy[1], p_cnt);
    end
    p_alloc_en = 1'b1; p_alloc_idx = 6'd63;
    p_wr_en = 2'b11; p_wr_idx = {6'd0, 6'd0}; p_wr_data = {32'hF00D, 32'hBEEF};
    #1;
    n_checks++;
    if (p_rd_data[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL par_x0_bypass got %h exp 0", p_rd_data[1]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (p_cnt !== 7'd1 || p_conf !== 1'b0 || p_rd_busy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL par_alloc got cnt=%0d conf=%b busy=%b exp 1/0/1", p_cnt, p_conf, p_rd_busy[0]);
    end
    p_wr_en = 2'b11; p_wr_idx = {6'd63, 6'd63}; p_wr_data = {32'h2, 32'h1};
    #1;
    n_checks++;
    if (p_rd_data[0] !== 32'h1 || p_rd_busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL par_coll_bypass got %h/%b exp 1/0", p_rd_data[0], p_rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (p_conf !== 1'b1 || p_rd_data[0] !== 32'h1 || p_cnt !== 7'd0) begin
      n_errors++;
      $display("FAIL par_coll got conf=%b data=%h cnt=%0d exp 1/1/0", p_conf, p_rd_data[0], p_cnt);
    end
    tick();
    n_checks++;
    if (p_conf !== 1'b0) begin
      n_errors++;
      $display("FAIL par_coll_clear got %b exp 0", p_conf);
    end
  endtask

  task automatic test_random();
    word_t ed;
    bit    eb;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      for (int ch = 0; ch < 4; ch++) begin
        wr_en[ch]   = ($urandom_range(0, 99) < 40);
        wr_idx[ch]  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_data[ch] = $urandom;
      end
      alloc_en  = ($urandom_range(0, 99) < 45);
      alloc_idx = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 99) < 4);
      for (int r = 0; r < 8; r++) rd_idx[r] = 5'($urandom_range(0, 31));
      #1;
      for (int r = 0; r < 8; r++) begin
        exp_rd(rd_idx[r], 1'b1, ed, eb);
        n_checks++;
        if (rd_data_b[r] !== ed || rd_busy_b[r] !== eb) begin
          n_errors++;
          $display("FAIL rnd_rd_byp cyc=%0d ch=%0d idx=%0d got %h/%b exp %h/%b",
                   cyc, r, rd_idx[r], rd_data_b[r], rd_busy_b[r], ed, eb);
        end
        exp_rd(rd_idx[r], 1'b0, ed, eb);
        n_checks++;
        if (rd_data_n[r] !== ed || rd_busy_n[r] !== eb) begin
          n_errors++;
          $display("FAIL rnd_rd_nobyp cyc=%0d ch=%0d idx=%0d got %h/%b exp %h/%b",
                   cyc, r, rd_idx[r], rd_data_n[r], rd_busy_n[r], ed, eb);
        end
      end
      tick();
      n_checks++;
      if (conf_b !== m_conf || conf_n !== m_conf || cnt_b !== 6'(m_cnt) || cnt_n !== 6'(m_cnt)) begin
        n_errors++;
        $display("FAIL rnd_regd cyc=%0d got conf=%b/%b cnt=%0d/%0d exp conf=%b cnt=%0d",
                 cyc, conf_b, conf_n, cnt_b, cnt_n, m_conf, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    alloc_en = 1'b1; alloc_idx = 5'd12;
    wr_en[0] = 1'b1; wr_idx[0] = 5'd13; wr_data[0] = 32'hCAFE;
    tick();
    idle();
    rd_idx[0] = 5'd12; rd_idx[1] = 5'd13;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (cnt_b !== 6'd0 || rd_busy_b[0] !== 1'b0 || rd_data_n[1] !== 32'h0 || rd_data_b[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid got cnt=%0d busy=%b data=%h/%h exp 0/0/0/0",
               cnt_b, rd_busy_b[0], rd_data_b[1], rd_data_n[1]);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_collision();
    test_scoreboard();
    test_alloc_race();
    test_params();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
